// File: rtl/logic_toggle_pkg.sv
// Shared types for the toggle generator: controller states and combine operators.
package logic_toggle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

endpackage

// File: rtl/toggle_chan.sv
// One toggle channel: latched half-period, cycle counter, output level and edge flag.
// A zero half-period disables the channel: it never counts, toggles or pulses.
module toggle_chan #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [CNT_W-1:0] period_i,
    output logic             ch_o,
    output logic             edge_o,
    output logic             enabled_o
);

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic             terminal;

    // Terminal count is the last cycle of the half-period.
    assign terminal  = (cnt_q == (period_q - CNT_W'(1)));
    assign enabled_o = (period_q != '0);

    // Period capture, counting and toggling; load restarts the channel from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
            ch_o     <= 1'b0;
            edge_o   <= 1'b0;
        end else if (load) begin
            period_q <= period_i;
            cnt_q    <= '0;
            ch_o     <= 1'b0;
            edge_o   <= 1'b0;
        end else begin
            edge_o <= 1'b0;
            if (advance && enabled_o) begin
                if (terminal) begin
                    cnt_q  <= '0;
                    ch_o   <= ~ch_o;
                    edge_o <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/logic_toggle_gen.sv
// Multi-channel toggle generator with run/hold control, combined output and sync flag.
//
// state | meaning
// IDLE  | after reset; channels cleared, waiting for the first load
// RUN   | counters advance on every cycle with en high
// HOLD  | counters and outputs frozen until en returns high
//
// The edge that leaves HOLD (en high) already counts, so a channel frozen
// with k cycles left toggles k edges after en returns.
module logic_toggle_gen
    import logic_toggle_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [N_CH*CNT_W-1:0] period_i,
    input  logic [1:0]            op_i,
    output logic [N_CH-1:0]       ch_o,
    output logic [N_CH-1:0]       edge_o,
    output logic                  comb_o,
    output logic                  sync_o
);

    state_e          state_q;
    state_e          state_d;
    logic            advance;
    logic            comb_d;
    logic [N_CH-1:0] en_mask;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load wins over en, and en selects RUN or HOLD once out of IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = en ? RUN : HOLD;
            end
            RUN, HOLD: begin
                state_d = en ? RUN : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign advance = en && !load && (state_q != IDLE);

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        toggle_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .advance  (advance),
            .period_i (period_i[c*CNT_W +: CNT_W]),
            .ch_o     (ch_o[c]),
            .edge_o   (edge_o[c]),
            .enabled_o(en_mask[c])
        );
    end

    // Reduction of the current channel levels under the selected operator.
    always_comb begin
        comb_d = 1'b0;
        case (op_e'(op_i))
            OP_AND:  comb_d = &ch_o;
            OP_OR:   comb_d = |ch_o;
            OP_XOR:  comb_d = ^ch_o;
            OP_NAND: comb_d = ~&ch_o;
            default: comb_d = 1'b0;
        endcase
    end

    // Combined output lags ch_o by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comb_o <= 1'b0;
        end else begin
            comb_o <= comb_d;
        end
    end

    // Edge flags are already single-cycle, so sync needs no register of its own.
    assign sync_o = (edge_o == en_mask) && (|en_mask);

endmodule

// File: tb/tb_logic_toggle_gen.sv
// Scoreboard bench for logic_toggle_gen (N_CH=2, CNT_W=8).
// The model tracks, per channel, the number of counting edges since load:
// the level is (n / P) mod 2 and an edge pulse appears when n is a multiple of P.
module tb_logic_toggle_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] period_i;
    logic [1:0]  op_i;
    logic [1:0]  ch_o;
    logic [1:0]  edge_o;
    logic        comb_o;
    logic        sync_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] ch;
        logic [1:0] edg;
        logic       comb;
        logic       sync;
    } exp_t;

    exp_t exp_q[$];

    int         m_state;
    int         m_p[2];
    int         m_n[2];
    logic [1:0] m_ch;
    logic [1:0] m_edge;
    logic       m_comb;

    logic_toggle_gen #(
        .N_CH (2),
        .CNT_W(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .period_i(period_i),
        .op_i    (op_i),
        .ch_o    (ch_o),
        .edge_o  (edge_o),
        .comb_o  (comb_o),
        .sync_o  (sync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs after the edge, then compare.
    task automatic step(input logic r, input logic ld, input logic e,
                        input logic [1:0] op, input logic [15:0] per);
        exp_t       x;
        logic       comb_n;
        logic [1:0] mask;
        rst_n    = r;
        load     = ld;
        en       = e;
        op_i     = op;
        period_i = per;
        if (!r) begin
            m_state = 0;
            m_p[0] = 0; m_p[1] = 0;
            m_n[0] = 0; m_n[1] = 0;
            m_ch   = 2'b00;
            m_edge = 2'b00;
            m_comb = 1'b0;
        end else begin
            case (op)
                2'd0:    comb_n = m_ch[0] & m_ch[1];
                2'd1:    comb_n = m_ch[0] | m_ch[1];
                2'd2:    comb_n = m_ch[0] ^ m_ch[1];
                default: comb_n = ~(m_ch[0] & m_ch[1]);
            endcase
            m_edge = 2'b00;
            if (ld) begin
                m_p[0] = int'(per[7:0]);
                m_p[1] = int'(per[15:8]);
                m_n[0] = 0; m_n[1] = 0;
                m_ch    = 2'b00;
                m_state = e ? 1 : 2;
            end else if (m_state != 0) begin
                if (e) begin
                    for (int c = 0; c < 2; c++) begin
                        if (m_p[c] > 0) begin
                            m_n[c]++;
                            m_edge[c] = ((m_n[c] % m_p[c]) == 0);
                            m_ch[c]   = (((m_n[c] / m_p[c]) % 2) == 1);
                        end
                    end
                    m_state = 1;
                end else begin
                    m_state = 2;
                end
            end
            m_comb = comb_n;
        end
        mask[0] = (m_p[0] != 0);
        mask[1] = (m_p[1] != 0);
        x.ch   = m_ch;
        x.edg  = m_edge;
        x.comb = m_comb;
        x.sync = (m_edge == mask) && (mask != 2'b00);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            chk("ch",   32'(ch_o),   32'(x.ch));
            chk("edge", 32'(edge_o), 32'(x.edg));
            chk("comb", 32'(comb_o), 32'(x.comb));
            chk("sync", 32'(sync_o), 32'(x.sync));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; period_i = '0; op_i = 2'd0;
        m_state = 0; m_ch = '0; m_edge = '0; m_comb = 1'b0;
        m_p[0] = 0; m_p[1] = 0; m_n[0] = 0; m_n[1] = 0;

        // Reset, then en without load must stay idle.
        step(0, 0, 0, 2'd0, 16'h0000);
        step(0, 1, 1, 2'd1, 16'h0a05);
        chk("rst_ch", 32'(ch_o), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2'd0, 16'h0303);
        chk("idle_ch", 32'(ch_o), 32'd0);

        // Periods 5/10, AND; non-load period_i values must be ignored.
        step(1, 1, 1, 2'd0, 16'h0a05);
        for (int i = 1; i <= 22; i++) begin
            step(1, 0, 1, 2'd0, 16'($urandom));
            if (i == 4)  chk("a_ch_k4", 32'(ch_o), 32'd0);
            if (i == 5)  chk("a_ch_k5", 32'(ch_o), 32'd1);
            if (i == 10) chk("a_sync_k10", 32'(sync_o), 32'd1);
            if (i == 10) chk("a_ch_k10", 32'(ch_o), 32'd2);
            if (i == 15) chk("a_comb_k15", 32'(comb_o), 32'd0);
            if (i == 16) chk("a_comb_k16", 32'(comb_o), 32'd1);
            if (i == 20) chk("a_comb_k20", 32'(comb_o), 32'd1);
            if (i == 21) chk("a_comb_k21", 32'(comb_o), 32'd0);
        end

        // Freeze at cnt=2 of period 5 for three cycles, then resume.
        step(1, 1, 1, 2'd1, 16'h0a05);
        step(1, 0, 1, 2'd1, 16'h0000);
        step(1, 0, 1, 2'd1, 16'h0000);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd1, 16'h0000);
        step(1, 0, 1, 2'd1, 16'h0000);
        step(1, 0, 1, 2'd1, 16'h0000);
        chk("b_ch_before", 32'(ch_o), 32'd0);
        step(1, 0, 1, 2'd1, 16'h0000);
        chk("b_ch_resume", 32'(ch_o), 32'd1);
        chk("b_edge_resume", 32'(edge_o), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2'd1, 16'h0000);

        // Reload to 3/3 while running.
        step(1, 1, 1, 2'd2, 16'h0303);
        chk("c_ch_clear", 32'(ch_o), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 1, 2'd2, 16'h0000);
            if (i == 3) chk("c_sync_3", 32'(sync_o), 32'd1);
            if (i == 3) chk("c_ch_3", 32'(ch_o), 32'd3);
            if (i == 6) chk("c_sync_6", 32'(sync_o), 32'd1);
        end

        // Periods 1/0, XOR, then random operators.
        step(1, 1, 1, 2'd2, 16'h0001);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 1, (i <= 6) ? 2'd2 : 2'($urandom_range(0, 3)), 16'h0000);
            chk("d_sync", 32'(sync_o), 32'd1);
            chk("d_ch1", 32'(ch_o[1]), 32'd0);
        end

        // Reset on the edge where channel 0 would toggle.
        step(1, 1, 1, 2'd3, 16'h0a05);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2'd3, 16'h0000);
        step(0, 0, 1, 2'd3, 16'h0000);
        chk("e_rst_ch", 32'(ch_o), 32'd0);
        chk("e_rst_edge", 32'(edge_o), 32'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 2'd3, 16'h0000);
        chk("e_idle_ch", 32'(ch_o), 32'd0);

        // Load with en low enters HOLD; counting starts once en rises.
        step(1, 1, 0, 2'd1, 16'h0302);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd1, 16'h0000);
        step(1, 0, 1, 2'd1, 16'h0000);
        step(1, 0, 1, 2'd1, 16'h0000);
        chk("f_ch_2", 32'(ch_o), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 0, $urandom_range(0, 1) == 1, 2'd1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
